// File: rtl/mem_ctrl_pkg.sv
// Shared types for the memory channel arbiter: per-channel transaction state.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    WRITE_WAIT = 2'd2,
    RELAY      = 2'd3
  } channel_state_t;

endpackage

// File: rtl/mem_channel_arbiter_rr_picker.sv
// Rotate-priority find-first: one-hot grant of the first set req bit at or after ptr (mod N).
module rr_picker #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PW'((32'(ptr) + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_channel_arbiter.sv
// Round-robin arbiter from NUM_CONSUMERS requesters onto NUM_CHANNELS memory channels.
// Same-address read coalescing is built when MEM_READ_COALESCE_EN is defined.
module mem_channel_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_BITS     = 8,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned NUM_CONSUMERS = 4,
  parameter int unsigned NUM_CHANNELS  = 2,
  parameter int unsigned WRITE_ENABLE  = 1
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]                 mem_read_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]                 mem_read_ready,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]                 mem_write_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]                 mem_write_ready
);

  localparam int unsigned NC = NUM_CONSUMERS;
  localparam int unsigned CH = NUM_CHANNELS;
  localparam int unsigned PW = $clog2(NC);

  logic [NC-1:0]          busy, eligible, taken, released, read_fill, write_fill;
  logic [PW-1:0]          rr_ptr, rr_ptr_next;
  logic [CH-1:0][NC-1:0]  take_all, rel_all, fill_rd, fill_wr;

  assign eligible = (consumer_read_valid | ((WRITE_ENABLE != 0) ? consumer_write_valid : '0)) & ~busy;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    channel_state_t       state, state_next;
    logic [NC-1:0]        avail_in, req, pick, take, attach, rel;
    logic [PW-1:0]        pick_idx;
    logic                 rd_go, wr_go, is_read, rd_valid_q, wr_valid_q;
    logic [ADDR_BITS-1:0] rd_addr_q, wr_addr_q;
    logic [DATA_BITS-1:0] wr_data_q;

    // Lower-indexed channels get first choice; their takes are masked off here.
    if (i == 0) begin : g_head
      assign avail_in = eligible;
    end else begin : g_link
      assign avail_in = g_ch[i-1].avail_in & ~g_ch[i-1].take;
    end

    assign req = (state == IDLE) ? avail_in : '0;

    rr_picker #(.N(NC), .PW(PW)) u_pick (
      .req   (req),
      .ptr   (rr_ptr),
      .grant (pick)
    );

    always_comb begin
      pick_idx = '0;
      for (int unsigned k = 0; k < NC; k++)
        if (pick[k]) pick_idx = PW'(k);
      rd_go = |(pick & consumer_read_valid);
      wr_go = (WRITE_ENABLE != 0) && (|pick) && !rd_go;
      take  = pick;
`ifdef MEM_READ_COALESCE_EN
      if (rd_go)
        for (int unsigned k = 0; k < NC; k++)
          if (avail_in[k] && consumer_read_valid[k] &&
              consumer_read_address[k] == consumer_read_address[pick_idx])
            take[k] = 1'b1;
`endif
    end

    assign rel = (state == RELAY) ?
                 (attach & ~(is_read ? consumer_read_valid : consumer_write_valid)) : '0;

    always_comb begin
      state_next = state;
      case (state)
        IDLE:       if (rd_go) state_next = READ_WAIT;
                    else if (wr_go) state_next = WRITE_WAIT;
        READ_WAIT:  if (mem_read_ready[i]) state_next = RELAY;
        WRITE_WAIT: if (mem_write_ready[i]) state_next = RELAY;
        RELAY:      if ((attach & ~rel) == '0) state_next = IDLE;
        default:    state_next = IDLE;
      endcase
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        attach     <= '0;
        is_read    <= 1'b0;
        rd_valid_q <= 1'b0;
        wr_valid_q <= 1'b0;
        rd_addr_q  <= '0;
        wr_addr_q  <= '0;
        wr_data_q  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (rd_go) begin
              attach     <= take;
              is_read    <= 1'b1;
              rd_valid_q <= 1'b1;
              rd_addr_q  <= consumer_read_address[pick_idx];
            end else if (wr_go) begin
              attach     <= take;
              is_read    <= 1'b0;
              wr_valid_q <= 1'b1;
              wr_addr_q  <= consumer_write_address[pick_idx];
              wr_data_q  <= consumer_write_data[pick_idx];
            end
          end
          READ_WAIT:  if (mem_read_ready[i]) rd_valid_q <= 1'b0;
          WRITE_WAIT: if (mem_write_ready[i]) wr_valid_q <= 1'b0;
          RELAY:      attach <= attach & ~rel;
          default:    ;
        endcase
      end
    end

    assign take_all[i]          = take;
    assign rel_all[i]           = rel;
    assign fill_rd[i]           = (state == READ_WAIT && mem_read_ready[i]) ? attach : '0;
    assign fill_wr[i]           = (state == WRITE_WAIT && mem_write_ready[i]) ? attach : '0;
    assign mem_read_valid[i]    = rd_valid_q;
    assign mem_read_address[i]  = rd_addr_q;
    assign mem_write_valid[i]   = wr_valid_q;
    assign mem_write_address[i] = wr_addr_q;
    assign mem_write_data[i]    = wr_data_q;
  end

  // The pointer moves past the highest consumer taken by the last granting channel.
  always_comb begin
    taken       = '0;
    released    = '0;
    read_fill   = '0;
    write_fill  = '0;
    rr_ptr_next = rr_ptr;
    for (int unsigned c = 0; c < CH; c++) begin
      taken      = taken | take_all[c];
      released   = released | rel_all[c];
      read_fill  = read_fill | fill_rd[c];
      write_fill = write_fill | fill_wr[c];
      for (int unsigned k = 0; k < NC; k++)
        if (take_all[c][k]) rr_ptr_next = PW'((k + 1) % NC);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy                 <= '0;
      rr_ptr               <= '0;
      consumer_read_ready  <= '0;
      consumer_write_ready <= '0;
      consumer_read_data   <= '0;
    end else begin
      busy                 <= (busy | taken) & ~released;
      rr_ptr               <= rr_ptr_next;
      consumer_read_ready  <= (consumer_read_ready | read_fill) & ~released;
      consumer_write_ready <= (consumer_write_ready | write_fill) & ~released;
      for (int unsigned c = 0; c < CH; c++)
        for (int unsigned k = 0; k < NC; k++)
          if (fill_rd[c][k]) consumer_read_data[k] <= mem_read_data[c];
    end
  end

endmodule

// File: tb/tb_mem_channel_arbiter.sv
// Directed bench: one read-only single-channel arbiter and one dual-channel read/write arbiter.
module tb_mem_channel_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: NC=4, CH=1, read-only
  logic [3:0]       a_rv, a_rrdy, a_wv, a_wrdy;
  logic [3:0][7:0]  a_ra, a_rd, a_wa, a_wd;
  logic [0:0]       a_mrv, a_mrr, a_mwv, a_mwr;
  logic [0:0][7:0]  a_mra, a_mrd, a_mwa, a_mwd;

  // Instance B: NC=4, CH=2, read/write
  logic [3:0]       b_rv, b_rrdy, b_wv, b_wrdy;
  logic [3:0][7:0]  b_ra, b_rd, b_wa, b_wd;
  logic [1:0]       b_mrv, b_mrr, b_mwv, b_mwr;
  logic [1:0][7:0]  b_mra, b_mrd, b_mwa, b_mwd;

  mem_channel_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4),
                        .NUM_CHANNELS(1), .WRITE_ENABLE(0)) u_a (
    .clk(clk), .reset(rst),
    .consumer_read_valid(a_rv), .consumer_read_address(a_ra),
    .consumer_read_ready(a_rrdy), .consumer_read_data(a_rd),
    .consumer_write_valid(a_wv), .consumer_write_address(a_wa),
    .consumer_write_data(a_wd), .consumer_write_ready(a_wrdy),
    .mem_read_valid(a_mrv), .mem_read_address(a_mra),
    .mem_read_ready(a_mrr), .mem_read_data(a_mrd),
    .mem_write_valid(a_mwv), .mem_write_address(a_mwa),
    .mem_write_data(a_mwd), .mem_write_ready(a_mwr)
  );

  mem_channel_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4),
                        .NUM_CHANNELS(2), .WRITE_ENABLE(1)) u_b (
    .clk(clk), .reset(rst),
    .consumer_read_valid(b_rv), .consumer_read_address(b_ra),
    .consumer_read_ready(b_rrdy), .consumer_read_data(b_rd),
    .consumer_write_valid(b_wv), .consumer_write_address(b_wa),
    .consumer_write_data(b_wd), .consumer_write_ready(b_wrdy),
    .mem_read_valid(b_mrv), .mem_read_address(b_mra),
    .mem_read_ready(b_mrr), .mem_read_data(b_mrd),
    .mem_write_valid(b_mwv), .mem_write_address(b_mwa),
    .mem_write_data(b_mwd), .mem_write_ready(b_mwr)
  );

  int        n_assert = 0;
  int        n_fail   = 0;
  int        rem [4];
  int        order [$];
  logic [7:0] got [4];
  int        pulses;
  logic      prev_mrv;
  logic      stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int ord_at(input int i);
    return (order.size() > i) ? order[i] : -1;
  endfunction

  function automatic logic a_done();
    return (rem[0] == 0) && (rem[1] == 0) && (rem[2] == 0) && (rem[3] == 0) &&
           (a_rv == 4'b0) && (a_rrdy == 4'b0) && (a_mrv == 1'b0);
  endfunction

  // Consumers of instance A request rem[k] times; memory answers a cycle after valid with addr^0x8B.
  task automatic run_a(input int budget);
    int cyc = 0;
    while (cyc < budget && !a_done()) begin
      @(negedge clk);
      cyc++;
      a_mrr[0] = a_mrv[0] && !stall;
      a_mrd[0] = a_mra[0] ^ 8'h8B;
      if (a_mrv[0] && !prev_mrv) pulses++;
      prev_mrv = a_mrv[0];
      for (int k = 0; k < 4; k++) begin
        if (a_rrdy[k] && a_rv[k]) begin
          order.push_back(k);
          got[k]  = a_rd[k];
          a_rv[k] = 1'b0;
          rem[k]--;
        end else if (!a_rv[k] && !a_rrdy[k] && rem[k] > 0) begin
          a_rv[k] = 1'b1;
        end
      end
    end
    check("run_complete", 32'(a_done()), 32'd1);
  endtask

  initial begin
    int   exp1 [8];
    int   exp2 [4];
    logic seen_mwv, seen_wrdy, seen_mrv;
    exp1 = '{0, 1, 2, 3, 0, 1, 2, 3};
    exp2 = '{0, 1, 2, 0};

    rst = 1'b1;
    a_rv = '0; a_ra = '0; a_wv = '0; a_wa = '0; a_wd = '0; a_mrr = '0; a_mrd = '0; a_mwr = '0;
    b_rv = '0; b_ra = '0; b_wv = '0; b_wa = '0; b_wd = '0; b_mrr = '0; b_mrd = '0; b_mwr = '0;
    rem = '{0, 0, 0, 0};
    got = '{8'h0, 8'h0, 8'h0, 8'h0};
    pulses = 0; prev_mrv = 1'b0; stall = 1'b0;

    #1;
    check("rst_a_rrdy", 32'(a_rrdy), 32'h0);
    check("rst_a_rdata", 32'(a_rd), 32'h0);
    check("rst_a_mrv", 32'(a_mrv), 32'h0);
    check("rst_a_mra", 32'(a_mra), 32'h0);
    check("rst_b_mrv_mwv", {30'(0), b_mrv} | {28'(0), b_mwv, 2'b00}, 32'h0);
    check("rst_b_ready", {24'(0), b_wrdy, b_rrdy}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // All four read twice through one channel: strict rotation, second round from 0.
    a_ra = {8'h33, 8'h32, 8'h31, 8'h30};
    rem  = '{2, 2, 2, 2};
    run_a(200);
    check("rr_pulses", 32'(pulses), 32'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("rr_order_%0d", i), 32'(ord_at(i)), 32'(exp1[i]));
    check("rr_data0", 32'(got[0]), 32'hBB);
    check("rr_data1", 32'(got[1]), 32'hBA);
    check("rr_data2", 32'(got[2]), 32'hB9);
    check("rr_data3", 32'(got[3]), 32'hB8);

    // Consumer 0 re-requests at once; 1 and 2 must still be served before it returns.
    order.delete();
    rem = '{2, 1, 1, 0};
    run_a(200);
    for (int i = 0; i < 4; i++)
      check($sformatf("fair_order_%0d", i), 32'(ord_at(i)), 32'(exp2[i]));
    check("fair_count", 32'(order.size()), 32'd4);

    // Read-only instance ignores a write request.
    seen_mwv = 1'b0; seen_wrdy = 1'b0; seen_mrv = 1'b0;
    a_wa[2] = 8'h10; a_wd[2] = 8'h55; a_wv[2] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seen_mwv  = seen_mwv | a_mwv[0];
      seen_wrdy = seen_wrdy | (|a_wrdy);
      seen_mrv  = seen_mrv | a_mrv[0];
    end
    check("ro_mem_write_valid", 32'(seen_mwv), 32'd0);
    check("ro_write_ready", 32'(seen_wrdy), 32'd0);
    check("ro_mem_read_valid", 32'(seen_mrv), 32'd0);
    a_wv = '0;

    // Consumers 1 and 3 read the same address together.
    order.delete();
    pulses = 0;
    a_ra[1] = 8'h20; a_ra[3] = 8'h20;
    got = '{8'h0, 8'h0, 8'h0, 8'h0};
    rem = '{0, 1, 0, 1};
    run_a(100);
`ifdef MEM_READ_COALESCE_EN
    check("co_pulses", 32'(pulses), 32'd1);
`else
    check("co_pulses", 32'(pulses), 32'd2);
`endif
    check("co_data1", 32'(got[1]), 32'hAB);
    check("co_data3", 32'(got[3]), 32'hAB);

    // Reset while a read waits on memory, then the held request is served again.
    stall = 1'b1;
    a_mrr = '0;
    a_ra[0] = 8'h44;
    seen_mrv = 1'b0;
    @(negedge clk);
    a_rv[0] = 1'b1;
    for (int i = 0; i < 10 && !seen_mrv; i++) begin
      @(negedge clk);
      seen_mrv = a_mrv[0];
    end
    check("mid_wait_reached", 32'(seen_mrv), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_mrv", 32'(a_mrv), 32'h0);
    check("async_rst_mra", 32'(a_mra), 32'h0);
    check("async_rst_rrdy", 32'(a_rrdy), 32'h0);
    check("async_rst_rdata", 32'(a_rd), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    stall = 1'b0;
    prev_mrv = 1'b0;
    order.delete();
    rem = '{1, 0, 0, 0};
    run_a(60);
    check("post_rst_order", 32'(ord_at(0)), 32'd0);
    check("post_rst_data", 32'(got[0]), 32'hCF);

    // Dual-channel instance: a read and a write issued in parallel.
    @(negedge clk);
    b_ra[0] = 8'h40; b_rv[0] = 1'b1;
    b_wa[1] = 8'h50; b_wd[1] = 8'h77; b_wv[1] = 1'b1;
    @(negedge clk);
    check("par_mrv", 32'(b_mrv), 32'h1);
    check("par_mra0", 32'(b_mra[0]), 32'h40);
    check("par_mwv", 32'(b_mwv), 32'h2);
    check("par_mwa1", 32'(b_mwa[1]), 32'h50);
    check("par_mwd1", 32'(b_mwd[1]), 32'h77);
    check("par_no_ready_yet", {24'(0), b_wrdy, b_rrdy}, 32'h0);
    b_mrr = 2'b01; b_mrd[0] = 8'hCB; b_mwr = 2'b10;
    @(negedge clk);
    b_mrr = '0; b_mwr = '0;
    check("par_rrdy", 32'(b_rrdy), 32'h1);
    check("par_rdata0", 32'(b_rd[0]), 32'hCB);
    check("par_wrdy", 32'(b_wrdy), 32'h2);
    check("par_mem_valids_low", {28'(0), b_mwv, b_mrv}, 32'h0);
    b_rv = '0; b_wv = '0;
    @(negedge clk);
    check("par_release", {24'(0), b_wrdy, b_rrdy}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
